stream_mux_rr: RTL

//   Parametrised, registered N-to-1 stream multiplexer with valid/ready handshake on every port.

---
 rtl/stream_mux_rr_pkg.sv | 17 +
 rtl/stream_mux_rr_arbiter.sv | 29 ++
 rtl/stream_mux_rr.sv | 78 +++++++
 3 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the registered N-to-1 stream multiplexer.
// Holds the output-register fill state and the pointer wrap helper.
package stream_mux_rr_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fill_t;

  function automatic int unsigned wrap_inc(
    input int unsigned g,
    input int unsigned n
  );
    return (g == n - 1) ? 32'd0 : g + 32'd1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority scan: first requester at or after ptr.
// Wraps modulo NUM_CH, so non-power-of-two channel counts work.
module rr_arbiter #(
  parameter  int NUM_CH = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_vld
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_vld && req[idx[SEL_W-1:0]]) begin
        grant     = idx[SEL_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream mux, static-select or round-robin grant.
// One output register with full-throughput valid/ready handshake.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int NUM_CH = 8,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  fill_t             state_q;
  fill_t             state_d;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_vld;
  logic [NUM_CH-1:0] sel_req;
  logic              s_vld;
  logic [SEL_W-1:0]  grant;
  logic              grant_vld;
  logic              load;
  logic              xfer;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_vld (rr_vld)
  );

  // Shift keeps out-of-range sel values from indexing past in_valid.
  assign sel_req   = in_valid >> sel;
  assign s_vld     = (int'(sel) < NUM_CH) && sel_req[0];

  assign grant     = mode ? rr_grant : sel;
  assign grant_vld = mode ? rr_vld : s_vld;

  assign out_valid = (state_q == ST_FULL);
  assign load      = !out_valid || out_ready;
  assign xfer      = load && grant_vld;
  assign in_ready  = xfer ? (NUM_CH'(1) << grant) : '0;

  always_comb begin
    state_d = state_q;
    if (load) state_d = grant_vld ? ST_FULL : ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_ch   <= grant;
      if (mode) rr_ptr <= SEL_W'(wrap_inc(32'(grant), NUM_CH));
    end
  end

endmodule
